// File: rtl/sram_bus_driver_pkg.sv
// Shared definitions for the SRAM/UART bus driver: FSM state encoding,
// bus widths and the memory-mapped UART register addresses.
package sram_bus_driver_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned MEM_ADDR_W = 16;

  localparam logic [MEM_ADDR_W-1:0] UART_DATA_ADDR_DEF = 16'hBF00;
  localparam logic [MEM_ADDR_W-1:0] UART_STAT_ADDR_DEF = 16'hBF01;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SRAM_RD      = 3'd1,
    SRAM_WR      = 3'd2,
    SRAM_WR_HOLD = 3'd3,
    UART_RD      = 3'd4,
    UART_WR      = 3'd5,
    UART_WR_WAIT = 3'd6,
    DONE         = 3'd7
  } bus_state_e;

  // UART status word as seen by the CPU: bit1 = rx data ready, bit0 = tx idle.
  function automatic logic [DATA_W-1:0] uart_status_word(input logic data_ready,
                                                         input logic tbre,
                                                         input logic tsre);
    return {14'b0, data_ready, tbre & tsre};
  endfunction

endpackage

// File: rtl/sram_bus_driver.sv
// Memory bus driver: turns single word requests from the memory arbiter into
// asynchronous SRAM cycles or memory-mapped UART accesses on a shared 16-bit
// tri-state data bus.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_enable_i/rw_i/addr_i/wdata_i  request from the arbiter (0=read, 1=write)
//   mem_rdata_o              last read data (held until the next read completes)
//   busy_o, done_o           access in flight / one-cycle completion pulse
//   sram_addr_o              zero-extended word address to the SRAM
//   sram_data_io             shared SRAM/UART data bus, Z unless writing
//   sram_ce_n_o/oe_n_o/we_n_o  SRAM strobes, active-low
//   uart_rdn_o, uart_wrn_o   UART strobes, active-low
//   uart_data_ready_i, uart_tbre_i, uart_tsre_i  UART status inputs
module sram_bus_driver
  import sram_bus_driver_pkg::*;
#(
  parameter int unsigned           ADDR_W         = 18,
  parameter logic [MEM_ADDR_W-1:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
  parameter logic [MEM_ADDR_W-1:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_enable_i,
  input  logic                  mem_rw_i,
  input  logic [MEM_ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  output logic [DATA_W-1:0]     mem_rdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_W-1:0]     sram_addr_o,
  inout  wire  [DATA_W-1:0]     sram_data_io,
  output logic                  sram_ce_n_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_we_n_o,
  output logic                  uart_rdn_o,
  output logic                  uart_wrn_o,
  input  logic                  uart_data_ready_i,
  input  logic                  uart_tbre_i,
  input  logic                  uart_tsre_i
);

  bus_state_e          state, state_nxt;
  logic                rd_phase, rd_phase_nxt;
  logic                busy_nxt, done_nxt;
  logic                ce_n_nxt, oe_n_nxt, we_n_nxt, rdn_nxt, wrn_nxt;
  logic                drive_en, drive_nxt;
  logic [DATA_W-1:0]   wdata_q, wdata_nxt;
  logic [DATA_W-1:0]   rdata_nxt;
  logic [ADDR_W-1:0]   addr_nxt;

  // Bus is only driven from a register, so it switches cleanly on clock edges.
  assign sram_data_io = drive_en ? wdata_q : 'z;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_phase    <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      sram_ce_n_o <= 1'b1;
      sram_oe_n_o <= 1'b1;
      sram_we_n_o <= 1'b1;
      uart_rdn_o  <= 1'b1;
      uart_wrn_o  <= 1'b1;
      drive_en    <= 1'b0;
      wdata_q     <= '0;
      mem_rdata_o <= '0;
      sram_addr_o <= '0;
    end else begin
      state       <= state_nxt;
      rd_phase    <= rd_phase_nxt;
      busy_o      <= busy_nxt;
      done_o      <= done_nxt;
      sram_ce_n_o <= ce_n_nxt;
      sram_oe_n_o <= oe_n_nxt;
      sram_we_n_o <= we_n_nxt;
      uart_rdn_o  <= rdn_nxt;
      uart_wrn_o  <= wrn_nxt;
      drive_en    <= drive_nxt;
      wdata_q     <= wdata_nxt;
      mem_rdata_o <= rdata_nxt;
      sram_addr_o <= addr_nxt;
    end
  end

  // Next state plus the output values that belong to that next state.
  always_comb begin
    state_nxt    = state;
    rd_phase_nxt = 1'b0;
    busy_nxt     = 1'b1;
    done_nxt     = 1'b0;
    ce_n_nxt     = 1'b1;
    oe_n_nxt     = 1'b1;
    we_n_nxt     = 1'b1;
    rdn_nxt      = 1'b1;
    wrn_nxt      = 1'b1;
    drive_nxt    = 1'b0;
    wdata_nxt    = wdata_q;
    rdata_nxt    = mem_rdata_o;
    addr_nxt     = sram_addr_o;

    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (mem_enable_i) begin
          addr_nxt  = ADDR_W'(mem_addr_i);
          wdata_nxt = mem_wdata_i;
          busy_nxt  = 1'b1;
          if (mem_addr_i == UART_DATA_ADDR) begin
            if (mem_rw_i) begin
              state_nxt = UART_WR;
              wrn_nxt   = 1'b0;
              drive_nxt = 1'b1;
            end else begin
              state_nxt = UART_RD;
              rdn_nxt   = 1'b0;
            end
          end else if (mem_addr_i == UART_STAT_ADDR) begin
            // Status register needs no bus cycle; writes to it are dropped.
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            if (!mem_rw_i) begin
              rdata_nxt = uart_status_word(uart_data_ready_i, uart_tbre_i, uart_tsre_i);
            end
          end else if (mem_rw_i) begin
            state_nxt = SRAM_WR;
            ce_n_nxt  = 1'b0;
            we_n_nxt  = 1'b0;
            drive_nxt = 1'b1;
          end else begin
            // First read cycle only presents the address with the bus released.
            state_nxt = SRAM_RD;
          end
        end
      end

      SRAM_RD: begin
        if (!rd_phase) begin
          rd_phase_nxt = 1'b1;
          ce_n_nxt     = 1'b0;
          oe_n_nxt     = 1'b0;
        end else begin
          rdata_nxt = sram_data_io;
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end

      SRAM_WR: begin
        // we_n rises while data stays on the bus to meet SRAM hold time.
        state_nxt = SRAM_WR_HOLD;
        ce_n_nxt  = 1'b0;
        drive_nxt = 1'b1;
      end

      SRAM_WR_HOLD: begin
        state_nxt = DONE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
      end

      UART_RD: begin
        rdata_nxt = {8'h00, sram_data_io[7:0]};
        state_nxt = DONE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
      end

      UART_WR: begin
        state_nxt = UART_WR_WAIT;
        drive_nxt = 1'b1;
      end

      UART_WR_WAIT: begin
        // Hold the byte on the bus until the transmitter has fully drained.
        if (uart_tbre_i && uart_tsre_i) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          drive_nxt = 1'b1;
        end
      end

      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_bus_driver.sv
// Directed bench for sram_bus_driver with a small SRAM/UART bus model.
module tb_sram_bus_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_enable;
  logic        mem_rw;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy, done;
  logic [17:0] sram_addr;
  wire  [15:0] sram_data;
  logic        ce_n, oe_n, we_n, rdn, wrn;
  logic        data_ready, tbre, tsre;

  logic [15:0] mem [0:255];
  logic [7:0]  uart_byte;
  logic        probe_en;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0, we_low_cnt = 0, wrn_low_cnt = 0, rdn_low_cnt = 0, oe_low_cnt = 0;
  int base;

  always #5 clk = ~clk;

  sram_bus_driver dut (
    .clk(clk), .rst(rst),
    .mem_enable_i(mem_enable), .mem_rw_i(mem_rw), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata),
    .busy_o(busy), .done_o(done),
    .sram_addr_o(sram_addr), .sram_data_io(sram_data),
    .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n),
    .uart_rdn_o(rdn), .uart_wrn_o(wrn),
    .uart_data_ready_i(data_ready), .uart_tbre_i(tbre), .uart_tsre_i(tsre)
  );

  // Bus model: SRAM drives on ce/oe low, UART drives a junk upper byte on rdn low,
  // and the probe drives a pattern that only reads back intact if the DUT is off the bus.
  assign sram_data = probe_en ? 16'h3C3C :
                     (!ce_n && !oe_n) ? mem[sram_addr[7:0]] :
                     (!rdn) ? {8'hC3, uart_byte} : 'z;

  always @(negedge clk) begin
    if (!ce_n && !we_n) mem[sram_addr[7:0]] <= sram_data;
    if (done === 1'b1) done_cnt++;
    if (we_n === 1'b0) we_low_cnt++;
    if (wrn === 1'b0) wrn_low_cnt++;
    if (rdn === 1'b0) rdn_low_cnt++;
    if (oe_n === 1'b0) oe_low_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Bus must be released: the probe pattern has to come back unchanged.
  task automatic chk_bus_z(input string tag);
    probe_en = 1'b1;
    #1;
    chk(tag, 32'(sram_data), 32'h3C3C);
    probe_en = 1'b0;
    #1;
  endtask

  task automatic req(input logic rw, input logic [15:0] a, input logic [15:0] d);
    mem_enable = 1'b1; mem_rw = rw; mem_addr = a; mem_wdata = d;
  endtask

  initial begin
    rst = 1'b1; mem_enable = 1'b0; mem_rw = 1'b0; mem_addr = '0; mem_wdata = '0;
    data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1; uart_byte = 8'h5A; probe_en = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_rdata", 32'(mem_rdata), 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_strobes", 32'({ce_n, oe_n, we_n, rdn, wrn}), 32'h1F);
    chk_bus_z("rst_bus_z");
    rst = 1'b0;
    tick();

    // SRAM write 0x0010 <= 0xA5A5
    base = we_low_cnt;
    req(1'b1, 16'h0010, 16'hA5A5);
    tick(); mem_enable = 1'b0;
    chk("wr_e1_busy", 32'(busy), 32'h1);
    chk("wr_e1_strobes", 32'({ce_n, oe_n, we_n}), 32'h2);
    chk("wr_e1_bus", 32'(sram_data), 32'hA5A5);
    chk("wr_e1_addr", 32'(sram_addr), 32'h00010);
    tick();
    chk("wr_e2_strobes", 32'({ce_n, oe_n, we_n}), 32'h3);
    chk("wr_e2_bus", 32'(sram_data), 32'hA5A5);
    chk("wr_e2_done", 32'(done), 32'h0);
    tick();
    chk("wr_e3_done", 32'(done), 32'h1);
    chk("wr_e3_busy", 32'(busy), 32'h0);
    chk("wr_e3_rdata_kept", 32'(mem_rdata), 32'h0);
    chk_bus_z("wr_e3_bus_z");
    tick();
    chk("wr_e4_done", 32'(done), 32'h0);
    chk("wr_we_low_cycles", 32'(we_low_cnt - base), 32'h1);
    chk("wr_mem", 32'(mem[16]), 32'hA5A5);

    // SRAM read 0x0010
    base = oe_low_cnt;
    req(1'b0, 16'h0010, 16'h0000);
    tick(); mem_enable = 1'b0;
    chk("rd_e1_busy", 32'(busy), 32'h1);
    chk("rd_e1_oe", 32'(oe_n), 32'h1);
    chk_bus_z("rd_e1_bus_z");
    tick();
    chk("rd_e2_strobes", 32'({ce_n, oe_n, we_n}), 32'h1);
    chk("rd_e2_done", 32'(done), 32'h0);
    tick();
    chk("rd_e3_done", 32'(done), 32'h1);
    chk("rd_e3_rdata", 32'(mem_rdata), 32'hA5A5);
    chk("rd_e3_oe", 32'(oe_n), 32'h1);
    chk_bus_z("rd_e3_bus_z");
    tick();
    chk("rd_oe_low_cycles", 32'(oe_low_cnt - base), 32'h1);

    // UART status read: ready=1, tbre=1, tsre=0
    data_ready = 1'b1; tbre = 1'b1; tsre = 1'b0;
    req(1'b0, 16'hBF01, 16'h0000);
    tick(); mem_enable = 1'b0;
    chk("stat_done", 32'(done), 32'h1);
    chk("stat_rdata", 32'(mem_rdata), 32'h0002);
    chk("stat_strobes", 32'({ce_n, oe_n, we_n, rdn, wrn}), 32'h1F);
    tick();
    chk("stat_done_pulse", 32'(done), 32'h0);

    // Status write: completes with no side effect
    req(1'b1, 16'hBF01, 16'hFFFF);
    tick(); mem_enable = 1'b0;
    chk("statwr_done", 32'(done), 32'h1);
    chk("statwr_rdata", 32'(mem_rdata), 32'h0002);
    tick();

    // UART write 0xBF00 <= 0x0041 with tsre low for 5 cycles
    base = wrn_low_cnt;
    data_ready = 1'b0; tsre = 1'b0;
    req(1'b1, 16'hBF00, 16'h0041);
    tick(); mem_enable = 1'b0;
    chk("uwr_e1_wrn", 32'(wrn), 32'h0);
    chk("uwr_e1_ce", 32'(ce_n), 32'h1);
    chk("uwr_e1_bus", 32'(sram_data), 32'h0041);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("uwr_wait%0d_busy", i), 32'(busy), 32'h1);
      chk($sformatf("uwr_wait%0d_done", i), 32'(done), 32'h0);
      chk($sformatf("uwr_wait%0d_wrn", i), 32'(wrn), 32'h1);
    end
    tsre = 1'b1;
    tick();
    chk("uwr_done", 32'(done), 32'h1);
    chk("uwr_busy", 32'(busy), 32'h0);
    chk("uwr_rdata_kept", 32'(mem_rdata), 32'h0002);
    tick();
    chk("uwr_wrn_low_cycles", 32'(wrn_low_cnt - base), 32'h1);

    // UART read 0xBF00 with byte 0x5A
    base = rdn_low_cnt;
    req(1'b0, 16'hBF00, 16'h0000);
    tick(); mem_enable = 1'b0;
    chk("urd_e1_rdn", 32'(rdn), 32'h0);
    chk("urd_e1_ce", 32'(ce_n), 32'h1);
    tick();
    chk("urd_done", 32'(done), 32'h1);
    chk("urd_rdata", 32'(mem_rdata), 32'h005A);
    chk_bus_z("urd_bus_z");
    tick();
    chk("urd_rdn_low_cycles", 32'(rdn_low_cnt - base), 32'h1);

    // Second request while busy is dropped
    base = done_cnt;
    we_low_cnt = we_low_cnt;
    req(1'b0, 16'h0010, 16'h0000);
    tick();
    req(1'b1, 16'h0020, 16'h1234);
    chk("ovl_busy", 32'(busy), 32'h1);
    tick(); mem_enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("ovl_done_count", 32'(done_cnt - base), 32'h1);
    chk("ovl_rdata", 32'(mem_rdata), 32'hA5A5);
    chk("ovl_no_write", 32'(we_low_cnt), 32'h1);

    // Reset in SRAM_WR
    base = done_cnt;
    req(1'b1, 16'h0030, 16'h5555);
    tick(); mem_enable = 1'b0;
    chk("rstwr_we_low", 32'(we_n), 32'h0);
    rst = 1'b1;
    tick();
    chk("rstwr_strobes", 32'({ce_n, oe_n, we_n, rdn, wrn}), 32'h1F);
    chk("rstwr_busy", 32'(busy), 32'h0);
    chk("rstwr_done", 32'(done), 32'h0);
    chk("rstwr_rdata", 32'(mem_rdata), 32'h0);
    chk_bus_z("rstwr_bus_z");
    rst = 1'b0;
    tick(); tick(); tick();
    chk("rstwr_no_done", 32'(done_cnt - base), 32'h0);
    chk("rstwr_idle", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
